// File: rtl/axi_ram_arb_pkg.sv
// Shared types for the two-master axi_ram arbiter.
// Arbitration mode is selected by AXI_RAM_ARB_RR_EN (see axi_ram_arb_sel).
package axi_ram_arb_pkg;
    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
endpackage

// File: rtl/axi_ram_arb_sel.sv
// Two-request grant selector. AXI_RAM_ARB_RR_EN defined: round-robin on ties;
// undefined: master 0 wins ties.
module axi_ram_arb_sel
    import axi_ram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_grant,
    output logic                   grant
);
`ifndef AXI_RAM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant = 1'b0;
        if (req[0] && req[1]) begin
`ifdef AXI_RAM_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end
endmodule

// File: rtl/axi_ram_arbiter.sv
// Two-master to one-slave AXI4 arbiter in front of axi_ram; independent read
// and write paths, each locked for a full burst. Tie-break mode: AXI_RAM_ARB_RR_EN.
module axi_ram_arbiter
    import axi_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic [ID_WIDTH-1:0]   m0_axi_awid,
    input  logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
    input  logic [7:0]            m0_axi_awlen,
    input  logic [2:0]            m0_axi_awsize,
    input  logic [1:0]            m0_axi_awburst,
    input  logic                  m0_axi_awlock,
    input  logic [3:0]            m0_axi_awcache,
    input  logic [2:0]            m0_axi_awprot,
    input  logic                  m0_axi_awvalid,
    output logic                  m0_axi_awready,
    input  logic [DATA_WIDTH-1:0] m0_axi_wdata,
    input  logic [STRB_WIDTH-1:0] m0_axi_wstrb,
    input  logic                  m0_axi_wlast,
    input  logic                  m0_axi_wvalid,
    output logic                  m0_axi_wready,
    output logic [ID_WIDTH-1:0]   m0_axi_bid,
    output logic [1:0]            m0_axi_bresp,
    output logic                  m0_axi_bvalid,
    input  logic                  m0_axi_bready,
    input  logic [ID_WIDTH-1:0]   m0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    input  logic [7:0]            m0_axi_arlen,
    input  logic [2:0]            m0_axi_arsize,
    input  logic [1:0]            m0_axi_arburst,
    input  logic                  m0_axi_arlock,
    input  logic [3:0]            m0_axi_arcache,
    input  logic [2:0]            m0_axi_arprot,
    input  logic                  m0_axi_arvalid,
    output logic                  m0_axi_arready,
    output logic [ID_WIDTH-1:0]   m0_axi_rid,
    output logic [DATA_WIDTH-1:0] m0_axi_rdata,
    output logic [1:0]            m0_axi_rresp,
    output logic                  m0_axi_rlast,
    output logic                  m0_axi_rvalid,
    input  logic                  m0_axi_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]   m1_axi_awid,
    input  logic [ADDR_WIDTH-1:0] m1_axi_awaddr,
    input  logic [7:0]            m1_axi_awlen,
    input  logic [2:0]            m1_axi_awsize,
    input  logic [1:0]            m1_axi_awburst,
    input  logic                  m1_axi_awlock,
    input  logic [3:0]            m1_axi_awcache,
    input  logic [2:0]            m1_axi_awprot,
    input  logic                  m1_axi_awvalid,
    output logic                  m1_axi_awready,
    input  logic [DATA_WIDTH-1:0] m1_axi_wdata,
    input  logic [STRB_WIDTH-1:0] m1_axi_wstrb,
    input  logic                  m1_axi_wlast,
    input  logic                  m1_axi_wvalid,
    output logic                  m1_axi_wready,
    output logic [ID_WIDTH-1:0]   m1_axi_bid,
    output logic [1:0]            m1_axi_bresp,
    output logic                  m1_axi_bvalid,
    input  logic                  m1_axi_bready,
    input  logic [ID_WIDTH-1:0]   m1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] m1_axi_araddr,
    input  logic [7:0]            m1_axi_arlen,
    input  logic [2:0]            m1_axi_arsize,
    input  logic [1:0]            m1_axi_arburst,
    input  logic                  m1_axi_arlock,
    input  logic [3:0]            m1_axi_arcache,
    input  logic [2:0]            m1_axi_arprot,
    input  logic                  m1_axi_arvalid,
    output logic                  m1_axi_arready,
    output logic [ID_WIDTH-1:0]   m1_axi_rid,
    output logic [DATA_WIDTH-1:0] m1_axi_rdata,
    output logic [1:0]            m1_axi_rresp,
    output logic                  m1_axi_rlast,
    output logic                  m1_axi_rvalid,
    input  logic                  m1_axi_rready,
    // slave (axi_ram)
    output logic [ID_WIDTH-1:0]   s_axi_awid,
    output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    output logic [7:0]            s_axi_awlen,
    output logic [2:0]            s_axi_awsize,
    output logic [1:0]            s_axi_awburst,
    output logic                  s_axi_awlock,
    output logic [3:0]            s_axi_awcache,
    output logic [2:0]            s_axi_awprot,
    output logic                  s_axi_awvalid,
    input  logic                  s_axi_awready,
    output logic [DATA_WIDTH-1:0] s_axi_wdata,
    output logic [STRB_WIDTH-1:0] s_axi_wstrb,
    output logic                  s_axi_wlast,
    output logic                  s_axi_wvalid,
    input  logic                  s_axi_wready,
    input  logic [ID_WIDTH-1:0]   s_axi_bid,
    input  logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_bvalid,
    output logic                  s_axi_bready,
    output logic [ID_WIDTH-1:0]   s_axi_arid,
    output logic [ADDR_WIDTH-1:0] s_axi_araddr,
    output logic [7:0]            s_axi_arlen,
    output logic [2:0]            s_axi_arsize,
    output logic [1:0]            s_axi_arburst,
    output logic                  s_axi_arlock,
    output logic [3:0]            s_axi_arcache,
    output logic [2:0]            s_axi_arprot,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    input  logic [ID_WIDTH-1:0]   s_axi_rid,
    input  logic [DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    input  logic                  s_axi_rlast,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    // status
    output logic                  wr_grant,
    output logic                  rd_grant,
    output logic                  wr_busy,
    output logic                  rd_busy
);
    localparam int AXW = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3;
    localparam int WW  = DATA_WIDTH + STRB_WIDTH + 1;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic      wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
    logic      wr_sel, rd_sel;

    logic [NUM_MASTERS-1:0][AXW-1:0] m_aw, m_ar;
    logic [NUM_MASTERS-1:0][WW-1:0]  m_w;
    logic [NUM_MASTERS-1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [NUM_MASTERS-1:0] m_awready, m_wready, m_bvalid, m_arready, m_rvalid;

    // Address/data payloads follow the registered grant; only handshakes are gated.
    assign m_aw[0] = {m0_axi_awid, m0_axi_awaddr, m0_axi_awlen, m0_axi_awsize,
                      m0_axi_awburst, m0_axi_awlock, m0_axi_awcache, m0_axi_awprot};
    assign m_aw[1] = {m1_axi_awid, m1_axi_awaddr, m1_axi_awlen, m1_axi_awsize,
                      m1_axi_awburst, m1_axi_awlock, m1_axi_awcache, m1_axi_awprot};
    assign m_ar[0] = {m0_axi_arid, m0_axi_araddr, m0_axi_arlen, m0_axi_arsize,
                      m0_axi_arburst, m0_axi_arlock, m0_axi_arcache, m0_axi_arprot};
    assign m_ar[1] = {m1_axi_arid, m1_axi_araddr, m1_axi_arlen, m1_axi_arsize,
                      m1_axi_arburst, m1_axi_arlock, m1_axi_arcache, m1_axi_arprot};
    assign m_w[0]  = {m0_axi_wdata, m0_axi_wstrb, m0_axi_wlast};
    assign m_w[1]  = {m1_axi_wdata, m1_axi_wstrb, m1_axi_wlast};

    assign {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
            s_axi_awlock, s_axi_awcache, s_axi_awprot} = m_aw[wr_grant_q];
    assign {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
            s_axi_arlock, s_axi_arcache, s_axi_arprot} = m_ar[rd_grant_q];
    assign {s_axi_wdata, s_axi_wstrb, s_axi_wlast} = m_w[wr_grant_q];

    assign m_awvalid = {m1_axi_awvalid, m0_axi_awvalid};
    assign m_wvalid  = {m1_axi_wvalid,  m0_axi_wvalid};
    assign m_bready  = {m1_axi_bready,  m0_axi_bready};
    assign m_arvalid = {m1_axi_arvalid, m0_axi_arvalid};
    assign m_rready  = {m1_axi_rready,  m0_axi_rready};

    assign {m1_axi_awready, m0_axi_awready} = m_awready;
    assign {m1_axi_wready,  m0_axi_wready}  = m_wready;
    assign {m1_axi_bvalid,  m0_axi_bvalid}  = m_bvalid;
    assign {m1_axi_arready, m0_axi_arready} = m_arready;
    assign {m1_axi_rvalid,  m0_axi_rvalid}  = m_rvalid;

    assign m0_axi_bid   = s_axi_bid;   assign m1_axi_bid   = s_axi_bid;
    assign m0_axi_bresp = s_axi_bresp; assign m1_axi_bresp = s_axi_bresp;
    assign m0_axi_rid   = s_axi_rid;   assign m1_axi_rid   = s_axi_rid;
    assign m0_axi_rdata = s_axi_rdata; assign m1_axi_rdata = s_axi_rdata;
    assign m0_axi_rresp = s_axi_rresp; assign m1_axi_rresp = s_axi_rresp;
    assign m0_axi_rlast = s_axi_rlast; assign m1_axi_rlast = s_axi_rlast;

    axi_ram_arb_sel u_wr_sel (.req(m_awvalid), .last_grant(wr_grant_q), .grant(wr_sel));
    axi_ram_arb_sel u_rd_sel (.req(m_arvalid), .last_grant(rd_grant_q), .grant(rd_sel));

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_grant_d    = wr_grant_q;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        m_awready     = '0;
        m_wready      = '0;
        m_bvalid      = '0;
        case (wr_state_q)
            W_IDLE: if (|m_awvalid) begin
                wr_grant_d = wr_sel;
                wr_state_d = W_ADDR;
            end
            W_ADDR: begin
                s_axi_awvalid         = m_awvalid[wr_grant_q];
                m_awready[wr_grant_q] = s_axi_awready;
                if (s_axi_awvalid && s_axi_awready) wr_state_d = W_DATA;
            end
            W_DATA: begin
                s_axi_wvalid         = m_wvalid[wr_grant_q];
                m_wready[wr_grant_q] = s_axi_wready;
                if (s_axi_wvalid && s_axi_wready && s_axi_wlast) wr_state_d = W_RESP;
            end
            W_RESP: begin
                m_bvalid[wr_grant_q] = s_axi_bvalid;
                s_axi_bready         = m_bready[wr_grant_q];
                if (s_axi_bvalid && s_axi_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_grant_d    = rd_grant_q;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        m_arready     = '0;
        m_rvalid      = '0;
        case (rd_state_q)
            R_IDLE: if (|m_arvalid) begin
                rd_grant_d = rd_sel;
                rd_state_d = R_ADDR;
            end
            R_ADDR: begin
                s_axi_arvalid         = m_arvalid[rd_grant_q];
                m_arready[rd_grant_q] = s_axi_arready;
                if (s_axi_arvalid && s_axi_arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                m_rvalid[rd_grant_q] = s_axi_rvalid;
                s_axi_rready         = m_rready[rd_grant_q];
                if (s_axi_rvalid && s_axi_rready && s_axi_rlast) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
        end
    end

    assign wr_grant = wr_grant_q;
    assign rd_grant = rd_grant_q;
    assign wr_busy  = (wr_state_q != W_IDLE);
    assign rd_busy  = (rd_state_q != R_IDLE);
endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Directed bench for axi_ram_arbiter with a small behavioural AXI RAM on the
// slave port. Tie-break expectations follow AXI_RAM_ARB_RR_EN.
module tb_axi_ram_arbiter;
    localparam int DW = 32, AW = 16, SW = 4, IW = 8;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    logic [IW-1:0] m_awid [2];  logic [AW-1:0] m_awaddr [2]; logic [7:0] m_awlen [2];
    logic [2:0] m_awsize [2];   logic [1:0] m_awburst [2];   logic m_awlock [2];
    logic [3:0] m_awcache [2];  logic [2:0] m_awprot [2];    logic m_awvalid [2], m_awready [2];
    logic [DW-1:0] m_wdata [2]; logic [SW-1:0] m_wstrb [2];  logic m_wlast [2], m_wvalid [2], m_wready [2];
    logic [IW-1:0] m_bid [2];   logic [1:0] m_bresp [2];     logic m_bvalid [2], m_bready [2];
    logic [IW-1:0] m_arid [2];  logic [AW-1:0] m_araddr [2]; logic [7:0] m_arlen [2];
    logic [2:0] m_arsize [2];   logic [1:0] m_arburst [2];   logic m_arlock [2];
    logic [3:0] m_arcache [2];  logic [2:0] m_arprot [2];    logic m_arvalid [2], m_arready [2];
    logic [IW-1:0] m_rid [2];   logic [DW-1:0] m_rdata [2];  logic [1:0] m_rresp [2];
    logic m_rlast [2], m_rvalid [2], m_rready [2];

    logic [IW-1:0] s_awid, s_arid, s_bid, s_rid;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [7:0] s_awlen, s_arlen;
    logic [2:0] s_awsize, s_arsize, s_awprot, s_arprot;
    logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
    logic s_awlock, s_arlock;
    logic [3:0] s_awcache, s_arcache;
    logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;
    logic wr_grant, rd_grant, wr_busy, rd_busy;

    axi_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .m0_axi_awid(m_awid[0]), .m0_axi_awaddr(m_awaddr[0]), .m0_axi_awlen(m_awlen[0]),
        .m0_axi_awsize(m_awsize[0]), .m0_axi_awburst(m_awburst[0]), .m0_axi_awlock(m_awlock[0]),
        .m0_axi_awcache(m_awcache[0]), .m0_axi_awprot(m_awprot[0]), .m0_axi_awvalid(m_awvalid[0]),
        .m0_axi_awready(m_awready[0]), .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]),
        .m0_axi_wlast(m_wlast[0]), .m0_axi_wvalid(m_wvalid[0]), .m0_axi_wready(m_wready[0]),
        .m0_axi_bid(m_bid[0]), .m0_axi_bresp(m_bresp[0]), .m0_axi_bvalid(m_bvalid[0]),
        .m0_axi_bready(m_bready[0]), .m0_axi_arid(m_arid[0]), .m0_axi_araddr(m_araddr[0]),
        .m0_axi_arlen(m_arlen[0]), .m0_axi_arsize(m_arsize[0]), .m0_axi_arburst(m_arburst[0]),
        .m0_axi_arlock(m_arlock[0]), .m0_axi_arcache(m_arcache[0]), .m0_axi_arprot(m_arprot[0]),
        .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]), .m0_axi_rid(m_rid[0]),
        .m0_axi_rdata(m_rdata[0]), .m0_axi_rresp(m_rresp[0]), .m0_axi_rlast(m_rlast[0]),
        .m0_axi_rvalid(m_rvalid[0]), .m0_axi_rready(m_rready[0]),
        .m1_axi_awid(m_awid[1]), .m1_axi_awaddr(m_awaddr[1]), .m1_axi_awlen(m_awlen[1]),
        .m1_axi_awsize(m_awsize[1]), .m1_axi_awburst(m_awburst[1]), .m1_axi_awlock(m_awlock[1]),
        .m1_axi_awcache(m_awcache[1]), .m1_axi_awprot(m_awprot[1]), .m1_axi_awvalid(m_awvalid[1]),
        .m1_axi_awready(m_awready[1]), .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]),
        .m1_axi_wlast(m_wlast[1]), .m1_axi_wvalid(m_wvalid[1]), .m1_axi_wready(m_wready[1]),
        .m1_axi_bid(m_bid[1]), .m1_axi_bresp(m_bresp[1]), .m1_axi_bvalid(m_bvalid[1]),
        .m1_axi_bready(m_bready[1]), .m1_axi_arid(m_arid[1]), .m1_axi_araddr(m_araddr[1]),
        .m1_axi_arlen(m_arlen[1]), .m1_axi_arsize(m_arsize[1]), .m1_axi_arburst(m_arburst[1]),
        .m1_axi_arlock(m_arlock[1]), .m1_axi_arcache(m_arcache[1]), .m1_axi_arprot(m_arprot[1]),
        .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]), .m1_axi_rid(m_rid[1]),
        .m1_axi_rdata(m_rdata[1]), .m1_axi_rresp(m_rresp[1]), .m1_axi_rlast(m_rlast[1]),
        .m1_axi_rvalid(m_rvalid[1]), .m1_axi_rready(m_rready[1]),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
        .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock), .s_axi_awcache(s_awcache),
        .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid),
        .s_axi_wready(s_wready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid),
        .s_axi_bready(s_bready), .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready), .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
        .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
    );

    // Behavioural RAM slave; word i resets to 0xA5A5_<i>.
    logic [DW-1:0] mem [0:1023];
    logic [1:0] ws;
    logic rs;
    logic [AW-1:0] wa, ra, last_awaddr;
    logic [IW-1:0] wid, rid_q;
    logic [7:0] rlen, rcnt, last_awlen;
    logic [IW-1:0] ar_log [$];

    assign s_awready = (ws == 2'd0);
    assign s_wready  = (ws == 2'd1);
    assign s_bvalid  = (ws == 2'd2);
    assign s_bid     = wid;
    assign s_bresp   = 2'b00;
    assign s_arready = !rs;
    assign s_rvalid  = rs;
    assign s_rdata   = mem[ra[11:2]];
    assign s_rlast   = (rcnt == rlen);
    assign s_rid     = rid_q;
    assign s_rresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            ws <= 2'd0; rs <= 1'b0; wa <= '0; ra <= '0; wid <= '0; rid_q <= '0;
            rlen <= '0; rcnt <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= {16'hA5A5, i[15:0]};
        end else begin
            case (ws)
                2'd0: if (s_awvalid) begin
                    wa <= s_awaddr; wid <= s_awid; ws <= 2'd1;
                    last_awaddr <= s_awaddr; last_awlen <= s_awlen;
                end
                2'd1: if (s_wvalid) begin
                    mem[wa[11:2]] <= s_wdata; wa <= wa + 16'd4;
                    if (s_wlast) ws <= 2'd2;
                end
                2'd2: if (s_bready) ws <= 2'd0;
                default: ws <= 2'd0;
            endcase
            if (!rs) begin
                if (s_arvalid) begin
                    ra <= s_araddr; rlen <= s_arlen; rcnt <= 8'd0; rid_q <= s_arid; rs <= 1'b1;
                    ar_log.push_back(s_arid);
                end
            end else if (s_rready) begin
                if (rcnt == rlen) rs <= 1'b0;
                else begin ra <= ra + 16'd4; rcnt <= rcnt + 8'd1; end
            end
        end
    end

    function automatic logic [18:0] ctl();
        return {wr_busy, rd_busy, wr_grant, rd_grant, s_awvalid, s_wvalid, s_bready, s_arvalid,
                s_rready, m_awready[0], m_wready[0], m_bvalid[0], m_arready[0], m_rvalid[0],
                m_awready[1], m_wready[1], m_bvalid[1], m_arready[1], m_rvalid[1]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        checks++;
        errors++;
        $error("FAIL timeout_%s observed=no_handshake expected=handshake", tag);
    endtask

    task automatic send_aw(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id);
        int n;
        m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = len; m_awvalid[m] = 1'b1;
        for (n = 0; n < 200; n++) begin #1; if (m_awready[m]) break; @(negedge clk); end
        if (n == 200) tmo($sformatf("aw%0d", m));
        @(negedge clk); m_awvalid[m] = 1'b0;
    endtask

    task automatic send_w(input int m, input logic [7:0] len, input logic [DW-1:0] d0,
                          input logic [DW-1:0] step);
        int n;
        for (int b = 0; b <= int'(len); b++) begin
            m_wdata[m] = d0 + DW'(b) * step; m_wlast[m] = (b == int'(len)); m_wvalid[m] = 1'b1;
            for (n = 0; n < 200; n++) begin #1; if (m_wready[m]) break; @(negedge clk); end
            if (n == 200) tmo($sformatf("w%0d", m));
            @(negedge clk);
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    endtask

    task automatic get_b(input int m, input logic [IW-1:0] id);
        int n;
        m_bready[m] = 1'b1;
        for (n = 0; n < 200; n++) begin #1; if (m_bvalid[m]) break; @(negedge clk); end
        if (n == 200) tmo($sformatf("b%0d", m));
        chk($sformatf("bresp%0d", m), 64'(m_bresp[m]), 64'(0));
        chk($sformatf("bid%0d", m), 64'(m_bid[m]), 64'(id));
        @(negedge clk); m_bready[m] = 1'b0;
    endtask

    task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IW-1:0] id, input logic [DW-1:0] d0, input logic [DW-1:0] step);
        send_aw(m, addr, len, id);
        send_w(m, len, d0, step);
        get_b(m, id);
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [IW-1:0] id, input logic [DW-1:0] d0, input logic [DW-1:0] step);
        int n;
        m_arid[m] = id; m_araddr[m] = addr; m_arlen[m] = len; m_arvalid[m] = 1'b1;
        for (n = 0; n < 200; n++) begin #1; if (m_arready[m]) break; @(negedge clk); end
        if (n == 200) tmo($sformatf("ar%0d", m));
        @(negedge clk); m_arvalid[m] = 1'b0; m_rready[m] = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            for (n = 0; n < 200; n++) begin #1; if (m_rvalid[m]) break; @(negedge clk); end
            if (n == 200) tmo($sformatf("r%0d", m));
            chk($sformatf("rdata%0d_%0d", m, b), 64'(m_rdata[m]), 64'(d0 + DW'(b) * step));
            chk($sformatf("rid%0d", m), 64'(m_rid[m]), 64'(id));
            chk($sformatf("rlast%0d_%0d", m, b), 64'(m_rlast[m]), 64'(b == int'(len)));
            @(negedge clk);
        end
        m_rready[m] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ovl, ok;
        logic [IW-1:0] first_id, second_id;
        logic [IW-1:0] exp_log [4];
        for (int i = 0; i < 2; i++) begin
            m_awid[i] = '0; m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = 3'd2; m_awburst[i] = 2'b01;
            m_awlock[i] = 1'b0; m_awcache[i] = '0; m_awprot[i] = '0; m_awvalid[i] = 1'b0;
            m_wdata[i] = '0; m_wstrb[i] = '1; m_wlast[i] = 1'b0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
            m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = 3'd2; m_arburst[i] = 2'b01;
            m_arlock[i] = 1'b0; m_arcache[i] = '0; m_arprot[i] = '0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
        end

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'(ctl()), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // single write with W presented early; 1-cycle arbitration
        m_awid[0] = 8'h0A; m_awaddr[0] = 16'h0010; m_awlen[0] = 8'd3; m_awvalid[0] = 1'b1;
        m_wdata[0] = 32'h11; m_wvalid[0] = 1'b1;
        #1;
        chk("aw_idle_svalid", 64'(s_awvalid), 64'(0));
        chk("aw_idle_busy", 64'(wr_busy), 64'(0));
        @(negedge clk); #1;
        chk("aw_t1_svalid", 64'(s_awvalid), 64'(1));
        chk("aw_t1_busy", 64'(wr_busy), 64'(1));
        chk("aw_t1_addr", 64'(s_awaddr), 64'(16'h0010));
        chk("early_w_wready", 64'(m_wready[0]), 64'(0));
        chk("early_w_svalid", 64'(s_wvalid), 64'(0));
        send_aw(0, 16'h0010, 8'd3, 8'h0A);
        send_w(0, 8'd3, 32'h11, 32'h11);
        #1;
        chk("b_m0_valid", 64'(m_bvalid[0]), 64'(1));
        chk("b_m1_quiet", 64'(m_bvalid[1]), 64'(0));
        get_b(0, 8'h0A);
        chk("wr1_grant", 64'(wr_grant), 64'(0));
        chk("wr1_awlen", 64'(last_awlen), 64'(3));
        for (int i = 0; i < 4; i++)
            chk($sformatf("wr1_mem%0d", i), 64'(mem[4+i]), 64'(32'h11 * (i + 1)));

        // simultaneous AR, rd_grant = 0
`ifdef AXI_RAM_ARB_RR_EN
        first_id = 8'h1B; second_id = 8'h0A;
`else
        first_id = 8'h0A; second_id = 8'h1B;
`endif
        ar_log.delete();
        m_arid[0] = 8'h0A; m_araddr[0] = 16'h0000; m_arlen[0] = 8'd0; m_arvalid[0] = 1'b1;
        m_arid[1] = 8'h1B; m_araddr[1] = 16'h0100; m_arlen[1] = 8'd0; m_arvalid[1] = 1'b1;
        #1;
        chk("ar_idle_svalid", 64'(s_arvalid), 64'(0));
        @(negedge clk); #1;
        chk("ar_t1_svalid", 64'(s_arvalid), 64'(1));
        chk("ar_t1_grant", 64'(rd_grant), 64'(first_id == 8'h1B));
        chk("ar_t1_id", 64'(s_arid), 64'(first_id));
        fork
            do_read(0, 16'h0000, 8'd0, 8'h0A, 32'hA5A50000, 32'd0);
            do_read(1, 16'h0100, 8'd0, 8'h1B, 32'hA5A50040, 32'd0);
        join
        chk("ar_order_n", 64'(ar_log.size()), 64'(2));
        if (ar_log.size() == 2) begin
            chk("ar_order0", 64'(ar_log[0]), 64'(first_id));
            chk("ar_order1", 64'(ar_log[1]), 64'(second_id));
        end

        // concurrent write (m0) and read (m1)
        ovl = 1'b0;
        fork
            do_write(0, 16'h0020, 8'd0, 8'h0C, 32'hDEADBEEF, 32'd0);
            do_read(1, 16'h0040, 8'd0, 8'h1D, 32'hA5A50010, 32'd0);
            for (int c = 0; c < 20; c++) begin @(negedge clk); #2; if (wr_busy && rd_busy) ovl = 1'b1; end
        join
        chk("conc_overlap", 64'(ovl), 64'(1));
        chk("conc_mem", 64'(mem[8]), 64'(32'hDEADBEEF));

        // B backpressure from m1 while m0 waits with AW
        send_aw(1, 16'h0050, 8'd1, 8'h1E);
        send_w(1, 8'd1, 32'h100, 32'd1);
        m_awid[0] = 8'h0F; m_awaddr[0] = 16'h0060; m_awlen[0] = 8'd0; m_awvalid[0] = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (!(wr_busy && !s_awvalid && !m_awready[0] && m_bvalid[1] && !s_bready)) ok = 1'b0;
        end
        chk("bp_hold", 64'(ok), 64'(1));
        m_bready[1] = 1'b1;
        #1;
        chk("bp_bid", 64'(m_bid[1]), 64'(8'h1E));
        @(negedge clk); m_bready[1] = 1'b0; #1;
        chk("bp_idle_busy", 64'(wr_busy), 64'(0));
        chk("bp_idle_svalid", 64'(s_awvalid), 64'(0));
        @(negedge clk); #1;
        chk("bp_t2_svalid", 64'(s_awvalid), 64'(1));
        chk("bp_t2_grant", 64'(wr_grant), 64'(0));
        chk("bp_t2_addr", 64'(s_awaddr), 64'(16'h0060));
        send_aw(0, 16'h0060, 8'd0, 8'h0F);
        send_w(0, 8'd0, 32'h77, 32'd0);
        get_b(0, 8'h0F);
        chk("bp_mem", 64'(mem[24]), 64'(32'h77));
        chk("bp_mem1", 64'(mem[21]), 64'(32'h101));

        // m0 reads back to back while m1 keeps a request pending; rd_grant = 1 here
`ifdef AXI_RAM_ARB_RR_EN
        exp_log[0] = 8'h0A; exp_log[1] = 8'h1B; exp_log[2] = 8'h0A; exp_log[3] = 8'h0A;
`else
        exp_log[0] = 8'h0A; exp_log[1] = 8'h0A; exp_log[2] = 8'h0A; exp_log[3] = 8'h1B;
`endif
        ar_log.delete();
        fork
            for (int k = 0; k < 3; k++)
                do_read(0, 16'(k * 4), 8'd0, 8'h0A, 32'hA5A50000 + 32'(k), 32'd0);
            do_read(1, 16'h0004, 8'd0, 8'h1B, 32'hA5A50001, 32'd0);
        join
        chk("cont_n", 64'(ar_log.size()), 64'(4));
        if (ar_log.size() == 4)
            for (int k = 0; k < 4; k++) chk($sformatf("cont_order%0d", k), 64'(ar_log[k]), 64'(exp_log[k]));

        // reset at beat 2 of a len-7 write
        send_aw(0, 16'h0080, 8'd7, 8'h0E);
        for (int b = 0; b < 2; b++) begin
            m_wdata[0] = 32'h900 + 32'(b); m_wvalid[0] = 1'b1;
            #1; chk($sformatf("rst_pre_wready%0d", b), 64'(m_wready[0]), 64'(1));
            @(negedge clk);
        end
        m_wdata[0] = 32'h902;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_mid_ctl", 64'(ctl()), 64'(0));
        @(negedge clk);
        rst = 1'b0; m_wvalid[0] = 1'b0;
        do_write(1, 16'h0030, 8'd0, 8'h1F, 32'h5555AAAA, 32'd0);
        chk("post_rst_mem", 64'(mem[12]), 64'(32'h5555AAAA));
        chk("post_rst_grant", 64'(wr_grant), 64'(1));
        @(negedge clk); #1;
        chk("final_ctl_busy", 64'({wr_busy, rd_busy}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
